tonegen_cmd_writer: RTL and testbench
=====================================

# tonegen_cmd_writer

Host-side register-write sequencer for the tone generator. Accepts timed commands (address, data, delay) over a valid/ready stream, buffers them, and replays each as a single-cycle write on the tone generator's parallel configuration bus. After each write it waits a programmable number of prescaled ticks, so note and envelope changes follow a fixed rhythm without host pacing.

## Interface
- `TICK_DIV`, default 1000: clk cycles per delay tick; legal range ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: run enable; low freezes the FSM and prescaler, while the FIFO still accepts commands.
- `flush` in 1: synchronous; drops queued commands and aborts the wait.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on a clock edge where valid && ready.
- `cmd_addr` in 3: target register address.
- `cmd_data` in 8: register value.
- `cmd_delay` in 8: ticks to wait after this write (0–255).
- `bus_data` out 8: drives tone generator `ui_in`.
- `bus_addr` out 3: drives tone generator `uio_in[2:0]`.
- `bus_we` out 1: drives tone generator `uio_in[3]`; one-cycle write strobe.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Reset values:
  - `bus_data` = 0, `bus_addr` = 0, `bus_we` = 0.
  - `cmd_ready` = 1, `busy` = 0.
  - FSM in IDLE, FIFO empty, prescaler = 0, delay counter = 0.
- FSM states:
  - IDLE: if `ena` && FIFO non-empty, pop the head, register addr/data onto the bus, set `bus_we` = 1, go to WRITE.
  - WRITE: `bus_we` returns to 0. If delay = 0, go to IDLE; else load the delay counter and clear the prescaler, go to WAIT.
  - WAIT: the prescaler counts 0..TICK_DIV-1. On wrap, decrement the delay counter. When the counter reaches 0 on a wrap, go to IDLE.
- `ena` low: FSM, prescaler and delay counter hold their values. A WRITE already in progress still completes its strobe.
- `flush`:
  - Empties the FIFO.
  - WAIT goes to IDLE with counters cleared.
  - A strobe already on the bus is not retracted.
  - A push in the same cycle as `flush` is discarded.
- `bus_data` and `bus_addr` hold the last written values between writes.
- Delay arithmetic: the counter is 8 bits and the prescaler is $clog2(TICK_DIV) bits. With TICK_DIV = 1, a tick occurs every cycle.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - `cmd_ready` = !full.
  - Pop on empty and push on full never occur.

## Timing
- Accept edge E0 with an idle, empty writer: `bus_we` is high for exactly the cycle after edge E1, i.e. one clock of latency.
- Back-to-back queued commands: spacing between `bus_we` pulses is 2 + delay×TICK_DIV cycles (delay = 0 gives 2).
- `ena` low for k cycles during WAIT or IDLE extends the spacing by k.
- `busy` falls the cycle after the final WAIT→IDLE or WRITE→IDLE transition, provided the FIFO is empty.
- Asserting `rst_n` low at any point forces all outputs to their reset values immediately (asynchronous).

## Configuration
- `TONEGEN_CMD_FIFO_EN` defined: 4-entry command FIFO.
- Undefined: single-entry holding register; `cmd_ready` = !holding_valid, with no same-cycle pop/push bypass.
- FSM behaviour and timing are identical in both builds; only the buffering depth differs.

## Structure
- Shared package `tonegen_pkg`:
  - FSM state enum.
  - Bus widths (`TG_DATA_W` = 8, `TG_ADDR_W` = 3).
  - Command struct {addr, data, delay}.
  - Tone generator register address constants.
- Sub-module `tonegen_cmd_fifo`: command buffer, depth selected by the macro. The FSM, prescaler and bus registers live in the top module.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset: pulse `rst_n` low in the middle of WAIT → all outputs 0 and `cmd_ready` = 1 without waiting for a clock edge; no `bus_we` after release.
- Single command {addr 2, data 0x5A, delay 0} accepted at edge E0 → `bus_we` = 1 for one cycle after E1 with `bus_addr` = 2 and `bus_data` = 0x5A; `busy` = 0 two cycles later.
- Commands {1, 0x10, 3} then {4, 0x22, 0} → second strobe arrives 14 cycles after the first; bus holds 0x22/4 afterwards.
- `ena` = 0 while pushing 5 commands back-to-back (FIFO build) → 4 accepted, `cmd_ready` low on the 5th, no strobes. Raising `ena` → 4 strobes in order.
- `ena` low for 10 cycles during WAIT of a delay-2 command → strobe spacing is 2 + 8 + 10 = 20 cycles.
- `flush` during WAIT with 2 commands queued → no further strobes; `busy` = 0 on the next cycle; `cmd_ready` = 1.

Source files
------------

// File: rtl/tonegen_pkg.sv
// Shared types and constants for the tone generator command writer.
// Bus widths, command bundle, FSM states and register map.
package tonegen_pkg;

    localparam int TG_DATA_W     = 8;
    localparam int TG_ADDR_W     = 3;
    localparam int TG_DELAY_W    = 8;
    localparam int TG_FIFO_DEPTH = 4;

    localparam logic [TG_ADDR_W-1:0] TG_REG_FREQ_LO  = 3'd0;
    localparam logic [TG_ADDR_W-1:0] TG_REG_FREQ_HI  = 3'd1;
    localparam logic [TG_ADDR_W-1:0] TG_REG_WAVE     = 3'd2;
    localparam logic [TG_ADDR_W-1:0] TG_REG_VOLUME   = 3'd3;
    localparam logic [TG_ADDR_W-1:0] TG_REG_ATTACK   = 3'd4;
    localparam logic [TG_ADDR_W-1:0] TG_REG_DECAY    = 3'd5;
    localparam logic [TG_ADDR_W-1:0] TG_REG_SUSTAIN  = 3'd6;
    localparam logic [TG_ADDR_W-1:0] TG_REG_CTRL     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } tg_state_e;

    typedef struct packed {
        logic [TG_ADDR_W-1:0]  addr;
        logic [TG_DATA_W-1:0]  data;
        logic [TG_DELAY_W-1:0] delay;
    } tg_cmd_t;

endpackage

// File: rtl/tonegen_cmd_fifo.sv
// Command buffer for the writer: 4-entry FIFO with TONEGEN_CMD_FIFO_EN,
// otherwise a single holding register.
module tonegen_cmd_fifo
    import tonegen_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    push,
    input  tg_cmd_t push_cmd,
    input  logic    pop,
    output tg_cmd_t head,
    output logic    empty,
    output logic    full
);

`ifdef TONEGEN_CMD_FIFO_EN
    localparam int PTR_W = $clog2(TG_FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(TG_FIFO_DEPTH);

    tg_cmd_t          mem_q [TG_FIFO_DEPTH];
    tg_cmd_t          mem_d [TG_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_cmd;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TG_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
`else
    tg_cmd_t hold_q, hold_d;
    logic    vld_q, vld_d;

    // Push requires !full and pop requires !empty, so they never coincide.
    always_comb begin
        hold_d = hold_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (pop) begin
            vld_d = 1'b0;
        end else if (push) begin
            hold_d = push_cmd;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            vld_q  <= vld_d;
        end
    end

    assign head  = hold_q;
    assign empty = !vld_q;
    assign full  = vld_q;
`endif

endmodule

// File: rtl/tonegen_cmd_writer.sv
// Timed register-write sequencer driving the tone generator config bus.
// Buffer depth set by TONEGEN_CMD_FIFO_EN (see tonegen_cmd_fifo).
module tonegen_cmd_writer
    import tonegen_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  flush,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TG_ADDR_W-1:0]  cmd_addr,
    input  logic [TG_DATA_W-1:0]  cmd_data,
    input  logic [TG_DELAY_W-1:0] cmd_delay,
    output logic [TG_DATA_W-1:0]  bus_data,
    output logic [TG_ADDR_W-1:0]  bus_addr,
    output logic                  bus_we,
    output logic                  busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    tg_state_e             state_q, state_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [TG_DELAY_W-1:0] dly_q, dly_d;
    logic [TG_DATA_W-1:0]  bus_data_q, bus_data_d;
    logic [TG_ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic                  bus_we_q, bus_we_d;

    tg_cmd_t push_cmd;
    tg_cmd_t head;
    logic    push;
    logic    pop;
    logic    empty;
    logic    full;

    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready && !flush;
    assign push_cmd  = '{addr: cmd_addr, data: cmd_data, delay: cmd_delay};

    tonegen_cmd_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full)
    );

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        dly_d      = dly_q;
        bus_data_d = bus_data_q;
        bus_addr_d = bus_addr_q;
        bus_we_d   = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ena && !empty && !flush) begin
                    pop        = 1'b1;
                    bus_addr_d = head.addr;
                    bus_data_d = head.data;
                    bus_we_d   = 1'b1;
                    dly_d      = head.delay;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Strobe always drops here; only the state advance needs ena.
                if (flush) begin
                    dly_d   = '0;
                    pre_d   = '0;
                    state_d = ST_IDLE;
                end else if (ena) begin
                    pre_d   = '0;
                    state_d = (dly_q == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    dly_d   = '0;
                    pre_d   = '0;
                    state_d = ST_IDLE;
                end else if (ena) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        dly_d = dly_q - 1'b1;
                        if (dly_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            dly_q      <= '0;
            bus_data_q <= '0;
            bus_addr_q <= '0;
            bus_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            dly_q      <= dly_d;
            bus_data_q <= bus_data_d;
            bus_addr_q <= bus_addr_d;
            bus_we_q   <= bus_we_d;
        end
    end

    assign bus_data = bus_data_q;
    assign bus_addr = bus_addr_q;
    assign bus_we   = bus_we_q;
    assign busy     = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_tonegen_cmd_writer.sv
// Directed scoreboard bench for tonegen_cmd_writer at TICK_DIV = 4.
// Covers both buffer builds (TONEGEN_CMD_FIFO_EN defined or not).
module tb_tonegen_cmd_writer;
    import tonegen_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       flush = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic [7:0] cmd_delay = '0;
    logic       cmd_ready;
    logic [7:0] bus_data;
    logic [2:0] bus_addr;
    logic       bus_we;
    logic       busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          s0;
    logic [10:0] exp_q[$];
    int          strobe_cyc[$];

    tonegen_cmd_writer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_delay (cmd_delay),
        .bus_data  (bus_data),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest accepted command.
    always @(negedge clk) begin
        if (rst_n && bus_we) begin
            logic [10:0] e;
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", {21'd0, bus_addr, bus_data},
                    32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_addr", {29'd0, bus_addr}, {29'd0, e[10:8]});
                chk("strobe_data", {24'd0, bus_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic push(input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] dl);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_delay = dl;
        for (int i = 0; i < 64 && !done; i++) begin
            if (cmd_ready) begin
                last_acc = cyc + 1;
                exp_q.push_back({a, d});
                done = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("push_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_bus_data", {24'd0, bus_data}, 32'd0);
        chk("rst_bus_addr", {29'd0, bus_addr}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single command, one clock of latency.
        s0 = strobe_cyc.size();
        push(3'd2, 8'h5A, 8'd0);
        @(negedge clk);
        chk("single_we", {31'd0, bus_we}, 32'd1);
        chk("single_addr", {29'd0, bus_addr}, 32'd2);
        chk("single_data", {24'd0, bus_data}, 32'h5A);
        @(negedge clk);
        chk("single_we_low", {31'd0, bus_we}, 32'd0);
        chk("single_busy_low", {31'd0, busy}, 32'd0);
        chk("single_count", strobe_cyc.size(), s0 + 1);
        chk("single_latency", strobe_cyc[s0] - last_acc, 32'd1);

        // Delay-3 spacing: 2 + 3*4.
        s0 = strobe_cyc.size();
        push(3'd1, 8'h10, 8'd3);
        push(3'd4, 8'h22, 8'd0);
        wait_idle("pair_idle");
        chk("pair_count", strobe_cyc.size(), s0 + 2);
        chk("pair_spacing", strobe_cyc[s0+1] - strobe_cyc[s0], 32'd14);
        chk("pair_hold_data", {24'd0, bus_data}, 32'h22);
        chk("pair_hold_addr", {29'd0, bus_addr}, 32'd4);

        // Fill the buffer with the FSM frozen.
        s0 = strobe_cyc.size();
        ena = 1'b0;
`ifdef TONEGEN_CMD_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            push(3'(i), 8'h30 + 8'(i), 8'd0);
        end
`else
        push(3'd0, 8'h30, 8'd0);
`endif
        chk("full_ready_low", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1;
        cmd_addr  = 3'd7;
        cmd_data  = 8'hEE;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("frozen_no_strobe", strobe_cyc.size(), s0);
        chk("frozen_busy", {31'd0, busy}, 32'd1);
        ena = 1'b1;
        wait_idle("drain_idle");
`ifdef TONEGEN_CMD_FIFO_EN
        chk("drain_count", strobe_cyc.size(), s0 + 4);
`else
        chk("drain_count", strobe_cyc.size(), s0 + 1);
`endif

        // ena low 10 cycles during WAIT of a delay-2 command.
        s0 = strobe_cyc.size();
        push(3'd3, 8'h44, 8'd2);
        push(3'd5, 8'h55, 8'd0);
        @(negedge clk);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        ena = 1'b1;
        wait_idle("ena_idle");
        chk("ena_count", strobe_cyc.size(), s0 + 2);
        chk("ena_spacing", strobe_cyc[s0+1] - strobe_cyc[s0], 32'd20);

        // Flush during WAIT; a push in the flush cycle is dropped.
        s0 = strobe_cyc.size();
        push(3'd1, 8'h66, 8'd3);
        push(3'd2, 8'h77, 8'd0);
`ifdef TONEGEN_CMD_FIFO_EN
        push(3'd3, 8'h88, 8'd0);
`endif
        repeat (2) @(negedge clk);
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 3'd6;
        cmd_data  = 8'hBB;
        @(negedge clk);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_ready", {31'd0, cmd_ready}, 32'd1);
        chk("flush_we", {31'd0, bus_we}, 32'd0);
`ifdef TONEGEN_CMD_FIFO_EN
        chk("flush_pending", exp_q.size(), 32'd2);
`else
        chk("flush_pending", exp_q.size(), 32'd1);
`endif
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("flush_count", strobe_cyc.size(), s0 + 1);
        chk("flush_hold_data", {24'd0, bus_data}, 32'h66);
        chk("flush_hold_addr", {29'd0, bus_addr}, 32'd1);

        // Asynchronous reset in the middle of WAIT.
        s0 = strobe_cyc.size();
        push(3'd6, 8'h99, 8'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {24'd0, bus_data}, 32'd0);
        chk("mid_rst_addr", {29'd0, bus_addr}, 32'd0);
        chk("mid_rst_we", {31'd0, bus_we}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_count", strobe_cyc.size(), s0 + 1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_data", {24'd0, bus_data}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
